// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared types and constants for the routing-mux arbiter.
package arbitro_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    typedef logic [1:0] idx_t;
    localparam int NREQ = 4;
endpackage

// File: rtl/prioridade_circular.sv
// prioridade_circular: first requester at or after ptr, scanning upward mod 4.
module prioridade_circular
    import arbitro_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            ptr,
    output logic            found,
    output idx_t            idx
);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    idx_t              off;
    // rotate so that bit 0 is the ptr position, then a fixed priority pick
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        found = |req;
        idx   = ptr + off;
    end
endmodule

// File: rtl/arbitro_roteamento.sv
// arbitro_roteamento: round-robin arbiter driving the 4:1 routing mux select,
// with a bounded hold time per grant.
module arbitro_roteamento
    import arbitro_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output idx_t            SEL,
    output logic [NREQ-1:0] grant,
    output logic            valid
);
    state_t        state;
    idx_t          ptr;
    logic [CW-1:0] cnt;
    logic          rel;
    idx_t          sptr;
    logic          found;
    idx_t          idx;
    // on release the search restarts just past the current owner
    always_comb begin
        rel  = (state == GRANT) && (!req[SEL] || cnt == CW'(MAX_HOLD - 1));
        sptr = rel ? SEL + 2'd1 : ptr;
    end
    prioridade_circular u_prio (
        .req   (req),
        .ptr   (sptr),
        .found (found),
        .idx   (idx)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            SEL   <= '0;
            grant <= '0;
            valid <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else if (state == IDLE || rel) begin
            ptr <= sptr;
            if (found) begin
                SEL   <= idx;
                grant <= 4'b0001 << idx;
                valid <= 1'b1;
                cnt   <= '0;
                state <= GRANT;
            end else begin
                grant <= '0;
                valid <= 1'b0;
                state <= IDLE;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_arbitro_roteamento.sv
// tb_arbitro_roteamento: table vectors from the test plan plus random traffic
// against a behavioural round-robin model.
module tb_arbitro_roteamento;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] SEL;
    logic [3:0] grant;
    logic       valid;

    int passed = 0;
    int total  = 0;

    int m_valid = 0, m_sel = 0, m_ptr = 0, m_held = 0;

    typedef struct {
        logic       rn;
        logic [3:0] rq;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       vld;
    } vec_t;
    vec_t tbl[$];

    arbitro_roteamento #(.MAX_HOLD(MH), .CW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .SEL   (SEL),
        .grant (grant),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic int win(int p, logic [3:0] r);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic vec_t mk(logic rn, logic [3:0] rq, int sel, logic [3:0] gnt, logic vld);
        vec_t v;
        v.rn = rn; v.rq = rq; v.sel = 2'(sel); v.gnt = gnt; v.vld = vld;
        return v;
    endfunction

    task automatic model(logic rn, logic [3:0] r);
        int w;
        if (!rn) begin
            m_valid = 0; m_sel = 0; m_ptr = 0; m_held = 0;
        end else if (!m_valid || !r[m_sel] || m_held == MH - 1) begin
            if (m_valid) m_ptr = (m_sel + 1) % 4;
            w = win(m_ptr, r);
            if (w >= 0) begin
                m_valid = 1; m_sel = w; m_held = 0;
            end else begin
                m_valid = 0;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic check(string name, logic [1:0] s, logic [3:0] g, logic v);
        total++;
        if (SEL === s && grant === g && valid === v) passed++;
        else $display("FAIL %s: got SEL=%0d grant=%b valid=%b, want SEL=%0d grant=%b valid=%b",
                      name, SEL, grant, valid, s, g, v);
    endtask

    task automatic apply(logic rn, logic [3:0] r);
        @(negedge clk);
        rst_n = rn;
        req   = r;
        @(posedge clk);
        model(rn, r);
        #1;
        check("model", 2'(m_sel), m_valid ? 4'(1 << m_sel) : 4'b0000, m_valid != 0);
    endtask

    initial begin
        logic       rn;
        logic [3:0] r;
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0));
        tbl.push_back(mk(0, 4'b1111, 0, 4'b0000, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 4'b1111, i / 4, 4'(1 << (i / 4)), 1));
        tbl.push_back(mk(1, 4'b0100, 2, 4'b0100, 1));
        tbl.push_back(mk(1, 4'b0100, 2, 4'b0100, 1));
        tbl.push_back(mk(1, 4'b0000, 2, 4'b0000, 0));
        tbl.push_back(mk(1, 4'b0000, 2, 4'b0000, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, 4'b1000, 3, 4'b1000, 1));
        tbl.push_back(mk(1, 4'b0001, 0, 4'b0001, 1));
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1));
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1));
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1));
        tbl.push_back(mk(0, 4'b0010, 0, 4'b0000, 0));
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1));
        tbl.push_back(mk(1, 4'b0010, 1, 4'b0010, 1));

        foreach (tbl[i]) begin
            apply(tbl[i].rn, tbl[i].rq);
            check($sformatf("vec%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].vld);
        end

        // MAX_HOLD not reached: a lone requester that drops after one cycle
        apply(1, 4'b0000);
        apply(1, 4'b0100);
        check("short_grant", 2, 4'b0100, 1);
        apply(1, 4'b0000);
        check("short_idle", 2, 4'b0000, 0);

        for (int i = 0; i < 600; i++) begin
            rn = ($urandom_range(0, 49) != 0);
            r  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            apply(rn, r);
            total++;
            if ($onehot0(grant) && (valid == (grant != 0)) && (!valid || grant[SEL])) passed++;
            else $display("FAIL invariant: SEL=%0d grant=%b valid=%b", SEL, grant, valid);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/arbitro_roteamento.md
Name: arbitro_roteamento

Overview:
- Round-robin arbiter directly upstream of the 4:1 routing multiplexer.
- Watches four request lines, one per mux data input (A..D), and drives the mux's 2-bit SEL.
- Also drives a one-hot grant and a valid flag.
- Each granted source keeps the mux for at most MAX_HOLD cycles, so no source can starve the others.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles one grant may last (legal range 1..255).
- CW, default 8: hold-counter width; must satisfy 2**CW > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge.
- req  input  4  request vector; req[i] = source i (0=A, 1=B, 2=C, 3=D) wants the mux.
- SEL  output  2  select driven to the routing mux; registered.
- grant  output  4  one-hot copy of SEL while valid, else 4'b0000; registered.
- valid  output  1  1 while a grant is active; registered.

Behaviour:
- Reset (rst_n=0 at a rising edge), takes priority over all else:
  - state=IDLE, SEL=0, grant=0, valid=0, ptr=0, cnt=0.
  - Mid-grant reset drops the grant on that same edge.
- Internal state:
  - state ∈ {IDLE, GRANT}.
  - ptr (2 bits): the search start index.
  - cnt (CW bits): cycles the current grant has been held.
- Search function: starting at ptr, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). The winner is the first index with req set.
- IDLE:
  - If req != 0 at an edge, then on that edge: SEL=winner, grant=1<<winner, valid=1, cnt=0, state=GRANT.
  - Latency: request sampled at edge n; grant visible after edge n.
  - If req == 0, stay in IDLE, valid=0, and SEL holds its last value.
- GRANT, per edge:
  - Release occurs when req[SEL]==0 or cnt==MAX_HOLD-1.
  - No release: cnt=cnt+1; all other state unchanged.
  - On release: ptr=SEL+1 (mod 4, wraps 3→0), then search with the new ptr against the current req.
    - Winner exists: back-to-back grant on the same edge (no bubble); SEL/grant updated, cnt=0, stay in GRANT.
    - No winner: valid=0, grant=0, state=IDLE; SEL holds.
- Timeout case: the released source is searched last. If it alone still requests, it is re-granted immediately with cnt=0.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving pure rotation among active requesters.
- Invariants:
  - grant is one-hot or zero.
  - valid==(grant!=0).
  - When valid=1, grant[SEL]==1.
  - cnt never exceeds MAX_HOLD-1.
- Requests from non-granted sources have no effect until the next release.
- req changes between edges are ignored; the block is fully synchronous.

Decomposition:
- Shared package arbitro_pkg:
  - typedef state_t enum {IDLE, GRANT}.
  - typedef idx_t logic [1:0].
  - localparam NREQ = 4.
- One combinational sub-module prioridade_circular:
  - Inputs: req[3:0], ptr (idx_t).
  - Outputs: found, idx (idx_t).
  - Instantiated once; it serves both the IDLE and release searches.

Test Plan (MAX_HOLD=4 unless noted):
- Reset: hold rst_n=0 for 2 edges with req=4'b1111 → SEL=0, grant=0, valid=0. Release reset with req=4'b1111 → after the next edge SEL=0, grant=4'b0001, valid=1.
- Timeout rotation: req=4'b1111 held constant for 16 cycles → SEL sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3 with valid continuously 1 (no bubble).
- Early release/idle: only req[2] asserted for 2 cycles, then req=0 → grant=4'b0100 for exactly 2 cycles, then valid=0, grant=0, SEL stays 2.
- Sole requester re-grant: req=4'b1000 constant for 10 cycles → SEL=3 and valid=1 throughout; cnt wraps to 0 after every 4th cycle.
- Wrap-around fairness: req[3] active and granted; set req=4'b1001 and drop req[3] → next grant is SEL=0 (ptr wrapped 3→0).
- Mid-grant reset: during SEL=1 grant with cnt=2, assert rst_n=0 for one edge → valid=0, grant=0, SEL=0. With req=4'b0010 still high, the grant returns to SEL=1 one edge after reset releases, with cnt restarting at 0.
